// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the single-clock FIFO.
// Provides the level-counter width and an elaboration-time parameter check.
package fifo_pkg;

   // The level counter needs one extra bit so it can represent a completely full FIFO.
   function automatic int level_width(input int address_width);
      return address_width + 1;
   endfunction

   // Legal configuration: thresholds strictly ordered and within the storage depth.
   function automatic bit params_ok(input int data_width, input int address_width,
                                    input int afull_level, input int aempty_level);
      return (data_width >= 1) && (address_width >= 2) &&
             (aempty_level < afull_level) && (afull_level <= (1 << address_width));
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake and status bundle of sync_fifo.
// The slave modport is the FIFO itself; master is the producer/consumer side.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4
);
   localparam int LW = level_width(ADDRESS_WIDTH);

   logic [DATA_WIDTH-1:0] Data_in;
   logic                  WriteEn_in;
   logic                  Full_out;
   logic                  AlmostFull_out;
   logic                  ReadEn_in;
   logic [DATA_WIDTH-1:0] Data_out;
   logic                  Empty_out;
   logic                  AlmostEmpty_out;
   logic [LW-1:0]         Level_out;
   logic                  Overflow_out;
   logic                  Underflow_out;

   modport slave (
      input  Data_in, WriteEn_in, ReadEn_in,
      output Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out,
             Level_out, Overflow_out, Underflow_out
   );

   modport master (
      output Data_in, WriteEn_in, ReadEn_in,
      input  Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out,
             Level_out, Overflow_out, Underflow_out
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointers, fill-level counter, registered status flags and
// sticky error bits. Every flag is derived from the next level so it changes
// on the same edge as Level_out.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 4,
   parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 2,
   parameter int AEMPTY_LEVEL  = 2,
   localparam int LW           = level_width(ADDRESS_WIDTH)
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     Clear_in,
   input  logic                     WriteEn_in,
   input  logic                     ReadEn_in,
   output logic                     wr_acc,
   output logic                     rd_acc,
   output logic [ADDRESS_WIDTH-1:0] wr_ptr,
   output logic [ADDRESS_WIDTH-1:0] rd_ptr,
   output logic                     Full_out,
   output logic                     AlmostFull_out,
   output logic                     Empty_out,
   output logic                     AlmostEmpty_out,
   output logic [LW-1:0]            Level_out,
   output logic                     Overflow_out,
   output logic                     Underflow_out
);
   localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;

   logic [LW-1:0] level_q;
   logic [LW-1:0] level_nxt;

   // Clear overrides both requests, so nothing is accepted in a flush cycle.
   assign wr_acc    = !Clear_in && WriteEn_in && !Full_out;
   assign rd_acc    = !Clear_in && ReadEn_in  && !Empty_out;
   assign Level_out = level_q;

   // Next fill level: moves only when exactly one side is accepted.
   always_comb begin
      level_nxt = level_q;
      case ({wr_acc, rd_acc})
         2'b10:   level_nxt = level_q + LW'(1);
         2'b01:   level_nxt = level_q - LW'(1);
         default: level_nxt = level_q;
      endcase
   end

   // Binary pointers wrap naturally at FIFO_DEPTH; clear rewinds both.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (Clear_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
         if (rd_acc) rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
      end
   end

   // Level and status flags, all registered from the next level.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         level_q         <= '0;
         Empty_out       <= 1'b1;
         AlmostEmpty_out <= 1'b1;
         Full_out        <= 1'b0;
         AlmostFull_out  <= 1'b0;
      end else if (Clear_in) begin
         level_q         <= '0;
         Empty_out       <= 1'b1;
         AlmostEmpty_out <= 1'b1;
         Full_out        <= 1'b0;
         AlmostFull_out  <= 1'b0;
      end else begin
         level_q         <= level_nxt;
         Empty_out       <= (level_nxt == '0);
         AlmostEmpty_out <= (level_nxt <= LW'(AEMPTY_LEVEL));
         Full_out        <= (level_nxt == LW'(FIFO_DEPTH));
         AlmostFull_out  <= (level_nxt >= LW'(AFULL_LEVEL));
      end
   end

   // Sticky error bits: any rejected-by-state request latches until flush or reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Overflow_out  <= 1'b0;
         Underflow_out <= 1'b0;
      end else if (Clear_in) begin
         Overflow_out  <= 1'b0;
         Underflow_out <= 1'b0;
      end else begin
         if (WriteEn_in && Full_out) Overflow_out  <= 1'b1;
         if (ReadEn_in && Empty_out) Underflow_out <= 1'b1;
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO top level (storage array and read-data path).
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads; undefined gives a registered read with one cycle of latency.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4,
   parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 2,
   parameter int AEMPTY_LEVEL  = 2
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Clear_in,
   sync_fifo_if.slave  bus
);
   localparam int  FIFO_DEPTH = 1 << ADDRESS_WIDTH;
   localparam bit  PARAMS_OK  = params_ok(DATA_WIDTH, ADDRESS_WIDTH, AFULL_LEVEL, AEMPTY_LEVEL);

   if (!PARAMS_OK) begin : g_param_err
      $error("sync_fifo: illegal DATA_WIDTH/ADDRESS_WIDTH/AFULL_LEVEL/AEMPTY_LEVEL combination");
   end

   logic                     wr_acc;
   logic                     rd_acc;
   logic [ADDRESS_WIDTH-1:0] wr_ptr;
   logic [ADDRESS_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];

   sync_fifo_ctrl #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .AFULL_LEVEL   (AFULL_LEVEL),
      .AEMPTY_LEVEL  (AEMPTY_LEVEL)
   ) u_ctrl (
      .Clk             (Clk),
      .Rst_n           (Rst_n),
      .Clear_in        (Clear_in),
      .WriteEn_in      (bus.WriteEn_in),
      .ReadEn_in       (bus.ReadEn_in),
      .wr_acc          (wr_acc),
      .rd_acc          (rd_acc),
      .wr_ptr          (wr_ptr),
      .rd_ptr          (rd_ptr),
      .Full_out        (bus.Full_out),
      .AlmostFull_out  (bus.AlmostFull_out),
      .Empty_out       (bus.Empty_out),
      .AlmostEmpty_out (bus.AlmostEmpty_out),
      .Level_out       (bus.Level_out),
      .Overflow_out    (bus.Overflow_out),
      .Underflow_out   (bus.Underflow_out)
   );

   // Storage array: written only on an accepted write, never reset.
   always_ff @(posedge Clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.Data_in;
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented combinationally; a read simply advances the pointer.
   assign bus.Data_out = mem[rd_ptr];
`else
   logic [DATA_WIDTH-1:0] data_q;

   // Registered read: capture the head word on the accepting edge, hold otherwise
   // (including through a flush).
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)      data_q <= '0;
      else if (rd_acc) data_q <= mem[rd_ptr];
   end

   assign bus.Data_out = data_q;
`endif

endmodule
